fpu_out_arb: RTL



---
 rtl/fpu_out_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/fpu_out_arb.sv
// FPU output arbiter: picks one of div/mul/add per cycle toward the CPX,
// meters CPX buffer credits and ages the mul/add pipes against starvation.
module fpu_out_arb #(
  parameter int CREDITS  = 2,
  parameter int CW       = 4,
  parameter int MAX_WAIT = 7
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          div_vld,
  input  logic [1:0]    div_thread,
  input  logic          mul_vld,
  input  logic [1:0]    mul_thread,
  input  logic          add_vld,
  input  logic [1:0]    add_thread,
  input  logic          cpx_credit_ret,
  output logic [2:0]    dest_rdy,
  output logic [1:0]    req_thread,
  output logic          div_stall,
  output logic          mul_stall,
  output logic          add_stall,
  output logic [CW-1:0] credit_cnt,
  output logic          credit_ovf
);

  localparam logic [CW-1:0] CREDITS_C  = CW'(CREDITS);
  localparam logic [3:0]    MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]    mul_wait_reg, mul_wait_next;
  logic [3:0]    add_wait_reg, add_wait_next;
  logic [CW-1:0] credit_cnt_reg, credit_cnt_next;
  logic          credit_ovf_reg, credit_ovf_next;

  logic has_credit;
  logic add_aged;
  logic mul_aged;
  logic grant_div;
  logic grant_mul;
  logic grant_add;
  logic any_grant;

  // Grant must be combinational: the datapath flops the selected word at the
  // end of this same cycle. A credit returned now is only usable next cycle.
  always_comb begin
    has_credit = (credit_cnt_reg != '0) && !rst;
    add_aged   = add_vld && (add_wait_reg == MAX_WAIT_C);
    mul_aged   = mul_vld && (mul_wait_reg == MAX_WAIT_C);
    grant_div  = 1'b0;
    grant_mul  = 1'b0;
    grant_add  = 1'b0;
    if (has_credit) begin
      if (add_aged)      grant_add = 1'b1;
      else if (mul_aged) grant_mul = 1'b1;
      else if (div_vld)  grant_div = 1'b1;
      else if (mul_vld)  grant_mul = 1'b1;
      else if (add_vld)  grant_add = 1'b1;
    end
    any_grant = grant_div | grant_mul | grant_add;
  end

  always_comb begin
    dest_rdy   = {grant_div, grant_mul, grant_add};
    req_thread = 2'd0;
    unique case (1'b1)
      grant_div: req_thread = div_thread;
      grant_mul: req_thread = mul_thread;
      grant_add: req_thread = add_thread;
      default:   req_thread = 2'd0;
    endcase
    div_stall  = div_vld & ~grant_div;
    mul_stall  = mul_vld & ~grant_mul;
    add_stall  = add_vld & ~grant_add;
    credit_cnt = credit_cnt_reg;
    credit_ovf = credit_ovf_reg;
  end

  // Wait counters clear whenever the pipe is idle or served, so a stalled
  // result only ages while it is continuously refused.
  always_comb begin
    mul_wait_next = mul_wait_reg;
    if (!mul_vld || grant_mul)          mul_wait_next = 4'd0;
    else if (mul_wait_reg != MAX_WAIT_C) mul_wait_next = mul_wait_reg + 4'd1;

    add_wait_next = add_wait_reg;
    if (!add_vld || grant_add)          add_wait_next = 4'd0;
    else if (add_wait_reg != MAX_WAIT_C) add_wait_next = add_wait_reg + 4'd1;
  end

  always_comb begin
    credit_cnt_next = credit_cnt_reg;
    credit_ovf_next = credit_ovf_reg;
    unique case ({any_grant, cpx_credit_ret})
      2'b10: credit_cnt_next = credit_cnt_reg - CW'(1);
      2'b01: begin
        if (credit_cnt_reg == CREDITS_C) credit_ovf_next = 1'b1;
        else                             credit_cnt_next = credit_cnt_reg + CW'(1);
      end
      default: credit_cnt_next = credit_cnt_reg;
    endcase
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      mul_wait_reg   <= 4'd0;
      add_wait_reg   <= 4'd0;
      credit_cnt_reg <= CREDITS_C;
      credit_ovf_reg <= 1'b0;
    end else begin
      mul_wait_reg   <= mul_wait_next;
      add_wait_reg   <= add_wait_next;
      credit_cnt_reg <= credit_cnt_next;
      credit_ovf_reg <= credit_ovf_next;
    end
  end

endmodule
